// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the multi-port register file
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;
    localparam logic RESET_BIT   = 1'b0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits: set at issue, cleared at write-back
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr0_en,
    input  logic [AW-1:0]    wr0_addr,
    input  logic             wr1_en,
    input  logic [AW-1:0]    wr1_addr,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Issue beats write-back so a new producer stays visible to decode.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (iss_en && (iss_addr == AW'(r)) && (r != REG_ZERO)) begin
                busy_d[r] = 1'b1;
            end else if ((wr0_en && (wr0_addr == AW'(r))) ||
                         (wr1_en && (wr1_addr == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= {NREGS{RESET_BIT}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NRD-read / 2-write register file with busy scoreboard
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [XLEN-1:0]   wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [XLEN-1:0]   wr1_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .busy     (busy)
    );

    // wr1 is applied last so it wins a same-address conflict.
    always_comb begin
        mem_d = mem_q;
        if (wr0_en && (wr0_addr != AW'(REG_ZERO))) begin
            mem_d[wr0_addr] = wr0_data;
        end
        if (wr1_en && (wr1_addr != AW'(REG_ZERO))) begin
            mem_d[wr1_addr] = wr1_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= {XLEN{RESET_BIT}};
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = mem_q[addr];
            bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr1_en && (wr1_addr == addr)) begin
                data = wr1_data;
                bsy  = bsy & iss_en & (iss_addr == addr);
            end else if (wr0_en && (wr0_addr == addr)) begin
                data = wr0_data;
                bsy  = bsy & iss_en & (iss_addr == addr);
            end
`endif
            // Outputs are forced low during reset so any bypass path is masked too.
            if (reset || (addr == AW'(REG_ZERO))) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized + directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NRD   = 4;
    localparam int AW    = $clog2(NREGS);

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr0_en, wr1_en, iss_en;
    logic [AW-1:0]        wr0_addr, wr1_addr, iss_addr;
    logic [XLEN-1:0]      wr0_data, wr1_data;
    logic [AW-1:0]        rd_a [NRD];

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    always #5 clk = ~clk;

    always_comb begin
        rd_addr = '0;
        for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = rd_a[k];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 0;
            end
        end else begin
            if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
            if (wr0_en) m_busy[wr0_addr] = 0;
            if (wr1_en) m_busy[wr1_addr] = 0;
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        if (reset || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
`endif
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (reset || a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
        if (((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) &&
            !(iss_en && iss_addr == a)) return 0;
`endif
        return m_busy[a];
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("port%0d_data", k), rd_data[k*XLEN +: XLEN], exp_data(rd_a[k]));
            chk($sformatf("port%0d_busy", k), XLEN'(rd_busy[k]), XLEN'(exp_busy(rd_a[k])));
        end
    end

    task automatic idle();
        wr0_en = 0; wr1_en = 0; iss_en = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        rd_a[0] = AW'(a0); rd_a[1] = AW'(a1); rd_a[2] = AW'(a2); rd_a[3] = AW'(a3);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        wr0_addr = '0; wr1_addr = '0; iss_addr = '0; wr0_data = '0; wr1_data = '0;
        set_rd(1, 2, 15, 0);
        step(); step();
        for (int k = 0; k < NRD; k++) begin
            chk("reset_data", rd_data[k*XLEN +: XLEN], '0);
            chk("reset_busy", XLEN'(rd_busy[k]), '0);
        end
        reset = 1'b0;
        step();

        // Reset mid-operation
        wr0_en = 1; wr0_addr = 5; wr0_data = 64'hDEADBEEF;
        iss_en = 1; iss_addr = 7;
        step();
        idle(); set_rd(5, 7, 0, 0);
        @(negedge clk);
        chk("x5_written", rd_data[0 +: XLEN], 64'hDEADBEEF);
        chk("x7_busy", XLEN'(rd_busy[1]), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_data", rd_data[0 +: XLEN], '0);
        chk("async_rst_busy", XLEN'(rd_busy[1]), '0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("x5_after_rst", rd_data[0 +: XLEN], '0);
        step();

        // x0 protection
        wr0_en = 1; wr0_addr = 0; wr0_data = 64'h12345678;
        iss_en = 1; iss_addr = 0;
        step();
        idle(); set_rd(0, 0, 0, 0);
        @(negedge clk);
        chk("x0_data", rd_data[0 +: XLEN], '0);
        chk("x0_busy", XLEN'(rd_busy[0]), '0);
        step();

        // Dual-write conflict and independent dual writes
        wr0_en = 1; wr0_addr = 3; wr0_data = 64'h11;
        wr1_en = 1; wr1_addr = 3; wr1_data = 64'h22;
        step();
        wr0_addr = 4; wr0_data = 64'h33;
        wr1_addr = 5; wr1_data = 64'h44;
        step();
        idle(); set_rd(3, 4, 5, 0);
        @(negedge clk);
        chk("x3_wr1_wins", rd_data[0 +: XLEN], 64'h22);
        chk("model_x3", m_mem[3], 64'h22);
        chk("x4_wr0", rd_data[XLEN +: XLEN], 64'h33);
        chk("x5_wr1", rd_data[2*XLEN +: XLEN], 64'h44);
        step();

        // Scoreboard set / clear / same-cycle issue+write-back
        set_rd(9, 0, 0, 0);
        iss_en = 1; iss_addr = 9;
        step();
        idle();
        @(negedge clk);
        chk("x9_busy_set", XLEN'(rd_busy[0]), 1);
        step();
        wr0_en = 1; wr0_addr = 9; wr0_data = 64'h55;
        step();
        idle();
        @(negedge clk);
        chk("x9_busy_clr", XLEN'(rd_busy[0]), 0);
        chk("x9_data", rd_data[0 +: XLEN], 64'h55);
        step();
        iss_en = 1; iss_addr = 9; wr0_en = 1; wr0_addr = 9; wr0_data = 64'h56;
        step();
        idle();
        @(negedge clk);
        chk("x9_iss_wins", XLEN'(rd_busy[0]), 1);
        step();

        // Bypass behaviour
        wr0_en = 1; wr0_addr = 6; wr0_data = 64'h77; iss_en = 1; iss_addr = 6;
        step();
        idle(); set_rd(6, 0, 0, 0);
        wr1_en = 1; wr1_addr = 6; wr1_data = 64'hCAFE;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", rd_data[0 +: XLEN], 64'hCAFE);
        chk("bypass_busy", XLEN'(rd_busy[0]), 0);
`else
        chk("nobypass_data", rd_data[0 +: XLEN], 64'h77);
        chk("nobypass_busy", XLEN'(rd_busy[0]), 1);
`endif
        step();
        idle();
        @(negedge clk);
        chk("x6_after_edge", rd_data[0 +: XLEN], 64'hCAFE);
        chk("x6_busy_after", XLEN'(rd_busy[0]), 0);
        step();

        // Four ports concurrently with 64-bit data
        wr0_en = 1; wr0_addr = 1;  wr0_data = 64'h0123_4567_89AB_CDEF;
        wr1_en = 1; wr1_addr = 2;  wr1_data = 64'hFEDC_BA98_7654_3210;
        step();
        wr0_addr = 15; wr0_data = 64'hA5A5_5A5A_F00D_BEEF; wr1_en = 0;
        step();
        idle(); set_rd(1, 2, 15, 0);
        @(negedge clk);
        chk("p0_x1", rd_data[0 +: XLEN], 64'h0123_4567_89AB_CDEF);
        chk("p1_x2", rd_data[XLEN +: XLEN], 64'hFEDC_BA98_7654_3210);
        chk("p2_x15", rd_data[2*XLEN +: XLEN], 64'hA5A5_5A5A_F00D_BEEF);
        chk("p3_x0", rd_data[3*XLEN +: XLEN], '0);
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wr0_en   = ($urandom_range(0, 2) != 0);
            wr0_addr = AW'($urandom_range(0, NREGS - 1));
            wr0_data = {$urandom, $urandom};
            wr1_en   = ($urandom_range(0, 2) != 0);
            wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, NREGS - 1));
            wr1_data = {$urandom, $urandom};
            iss_en   = ($urandom_range(0, 1) != 0);
            iss_addr = ($urandom_range(0, 3) == 0) ? wr1_addr : AW'($urandom_range(0, NREGS - 1));
            for (int k = 0; k < NRD; k++) begin
                rd_a[k] = ($urandom_range(0, 2) == 0) ? wr1_addr : AW'($urandom_range(0, NREGS - 1));
            end
            if (i == 200) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
